// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between the RAM arbiter, its two requesters (fetch, data) and the shared RAM.
// timeout_err exists only when ARB_TIMEOUT_EN is defined.
interface ram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_done;

  logic              dm_req;
  logic              dm_we;
  logic [1:0]        dm_size;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_done;

  logic              ram_mfa;
  logic              ram_rw;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_size;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              ram_moc;

  logic              busy;
  logic              align_err;
`ifdef ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  // Arbiter view
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, ram_rdata, ram_moc,
    output if_rdata, if_done, dm_rdata, dm_done, ram_mfa, ram_rw, ram_addr, ram_size,
           ram_wdata, busy, align_err
`ifdef ARB_TIMEOUT_EN
    , output timeout_err
`endif
  );

  // Requester/RAM environment view
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, ram_rdata, ram_moc,
    input  if_rdata, if_done, dm_rdata, dm_done, ram_mfa, ram_rw, ram_addr, ram_size,
           ram_wdata, busy, align_err
`ifdef ARB_TIMEOUT_EN
    , input timeout_err
`endif
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter sharing one RAM between fetch and data ports with a four-phase MFA/MOC handshake.
// Optional ACCESS watchdog with sticky timeout_err when ARB_TIMEOUT_EN is defined.
module ram_access_arbiter #(
  parameter int unsigned ADDR_W = 9
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 15
`endif
) (
  input logic               clk,
  input logic               reset,
  ram_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, REJECT} state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 1 = data port
  logic              gnt_dm_q, gnt_dm_d;
  logic              mfa_q, mfa_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       dm_rdata_q, dm_rdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic              align_err_q, align_err_d;
  logic              busy_q, busy_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  logic sel_dm;
  logic dm_misaligned;
  logic misaligned;

  // Contest goes to the requester opposite the last grant
  assign sel_dm        = bus.dm_req && (!bus.if_req || !last_grant_q);
  assign dm_misaligned = (bus.dm_size == 2'b00) ? 1'b0 :
                         (bus.dm_size == 2'b01) ? bus.dm_addr[0] :
                                                  (bus.dm_addr[1:0] != 2'b00);
  assign misaligned    = sel_dm ? dm_misaligned : (bus.if_addr[1:0] != 2'b00);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_dm_d      = gnt_dm_q;
    mfa_d         = 1'b0;
    rw_d          = rw_q;
    addr_d        = addr_q;
    size_d        = size_q;
    wdata_d       = wdata_q;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    if_done_d     = 1'b0;
    dm_done_d     = 1'b0;
    align_err_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          last_grant_d = sel_dm;
          gnt_dm_d     = sel_dm;
          if (misaligned) begin
            state_d     = REJECT;
            if_done_d   = !sel_dm;
            dm_done_d   = sel_dm;
            align_err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            mfa_d   = 1'b1;
            addr_d  = sel_dm ? bus.dm_addr : bus.if_addr;
            rw_d    = sel_dm ? !bus.dm_we : 1'b1;
            size_d  = !sel_dm ? 2'b10 : ((bus.dm_size == 2'b11) ? 2'b10 : bus.dm_size);
            wdata_d = sel_dm ? bus.dm_wdata : 32'h0;
`ifdef ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (bus.ram_moc) begin
          state_d   = RELEASE;
          if_done_d = !gnt_dm_q;
          dm_done_d = gnt_dm_q;
          if (rw_q) begin
            if (gnt_dm_q) dm_rdata_d = bus.ram_rdata;
            else          if_rdata_d = bus.ram_rdata;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Give up: complete the request with stale rdata and flag it
          state_d       = RELEASE;
          if_done_d     = !gnt_dm_q;
          dm_done_d     = gnt_dm_q;
          timeout_err_d = 1'b1;
        end else begin
          mfa_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          mfa_d = 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (!bus.ram_moc) state_d = IDLE;
      end
      REJECT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b0;
      gnt_dm_q      <= 1'b0;
      mfa_q         <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      size_q        <= 2'b00;
      wdata_q       <= 32'h0;
      if_rdata_q    <= 32'h0;
      dm_rdata_q    <= 32'h0;
      if_done_q     <= 1'b0;
      dm_done_q     <= 1'b0;
      align_err_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_dm_q      <= gnt_dm_d;
      mfa_q         <= mfa_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      size_q        <= size_d;
      wdata_q       <= wdata_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      if_done_q     <= if_done_d;
      dm_done_q     <= dm_done_d;
      align_err_q   <= align_err_d;
      busy_q        <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.ram_mfa   = mfa_q;
  assign bus.ram_rw    = rw_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_size  = size_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.align_err = align_err_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized bench for ram_access_arbiter: a behavioural RAM plus a transaction-level model of
// grant order, alignment rejection, done timing and read-data return.
module tb_ram_access_arbiter;
  localparam int unsigned ADDR_W = 9;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_access_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  ram_access_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Behavioural RAM: answers MFA after lat cycles, holds MOC hold cycles after MFA falls
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              rw;
    logic [31:0]       wdata;
  } cmd_t;

  cmd_t        log_q[$];
  int          lat = 0, hold = 0;
  logic [31:0] next_rdata = 32'h0;
  bit          mute = 1'b0;
  int          lat_cnt = 0, hold_cnt = 0, moc_cyc = 0, mfa_rises = 0;
  bit          responded = 1'b0;
  logic        prev_mfa = 1'b0;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus.ram_moc   = 1'b0;
      bus.ram_rdata = 32'h0;
      responded     = 1'b0;
      lat_cnt       = 0;
      hold_cnt      = 0;
      prev_mfa      = 1'b0;
    end else begin
      if (bus.ram_mfa && !prev_mfa) mfa_rises++;
      prev_mfa = bus.ram_mfa;
      if (bus.ram_mfa && !responded && !mute) begin
        if (lat_cnt >= lat) begin
          bus.ram_moc   = 1'b1;
          bus.ram_rdata = next_rdata;
          responded     = 1'b1;
          moc_cyc       = cyc;
          lat_cnt       = 0;
          log_q.push_back('{bus.ram_addr, bus.ram_size, bus.ram_rw, bus.ram_wdata});
        end else lat_cnt++;
      end else if (!bus.ram_mfa && responded) begin
        if (hold_cnt >= hold) begin
          bus.ram_moc = 1'b0;
          responded   = 1'b0;
          hold_cnt    = 0;
        end else hold_cnt++;
      end
    end
  end

  // Reference model state
  bit          last_dm_m = 1'b0;
  logic [31:0] exp_if = 32'h0, exp_dm = 32'h0;

  function automatic bit misaligned_m(input bit is_dm, input logic [1:0] size,
                                      input logic [ADDR_W-1:0] addr);
    if (!is_dm) return (addr % 4) != 0;
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return (addr % 2) != 0;
      default: return (addr % 4) != 0;
    endcase
  endfunction

  // Called at the negedge of an IDLE cycle in which the requester is already pending
  task automatic serve(input bit is_dm, input bit we, input logic [1:0] size,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input int l, input int h, input logic [31:0] rd);
    automatic bit   mis   = misaligned_m(is_dm, size, addr);
    automatic int   log_n = log_q.size();
    automatic int   rises = mfa_rises;
    automatic bit   seen  = 1'b0;
    automatic int   extra = 0;
    automatic cmd_t cmd;
    next_rdata = rd;
    lat        = l;
    hold       = h;
    @(negedge clk);
    check("first_mfa", bus.ram_mfa, !mis);
    if (mis) check("first_reject", {bus.if_done, bus.dm_done, bus.align_err}, {!is_dm, is_dm, 1'b1});
    for (int i = 0; i < 40; i++) begin
      if (bus.if_done || bus.dm_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", seen, 1'b1);
    if (seen) begin
      check("done_who", {bus.if_done, bus.dm_done}, {!is_dm, is_dm});
      check("align_err", bus.align_err, mis);
      if (!mis) begin
        check("moc_to_done", cyc - moc_cyc, 1);
        check("access_count", log_q.size(), log_n + 1);
        if (log_q.size() > 0) begin
          cmd = log_q[log_q.size() - 1];
          check("ram_addr", cmd.addr, addr);
          check("ram_rw", cmd.rw, is_dm ? !we : 1'b1);
          check("ram_size", cmd.size, (!is_dm || size == 2'd3) ? 2'd2 : size);
          if (is_dm && we) check("ram_wdata", cmd.wdata, wdata);
        end
        if (!is_dm) exp_if = rd;
        else if (!we) exp_dm = rd;
      end else begin
        check("no_mfa_on_reject", mfa_rises, rises);
      end
      check("if_rdata", bus.if_rdata, exp_if);
      check("dm_rdata", bus.dm_rdata, exp_dm);
    end
    if (is_dm) bus.dm_req = 1'b0;
    else       bus.if_req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      if (bus.ram_mfa) check("mfa_in_release", bus.ram_mfa, 1'b0);
      extra++;
    end
    check("release_len", extra, mis ? 0 : h);
  endtask

  task automatic do_round(input bit use_if, input logic [ADDR_W-1:0] ia,
                          input bit use_dm, input bit we, input logic [1:0] sz,
                          input logic [ADDR_W-1:0] da, input logic [31:0] wd,
                          input int l, input int h, input logic [31:0] rd0, input logic [31:0] rd1);
    automatic bit first_dm = use_dm && (!use_if || !last_dm_m);
    bus.if_req   = use_if;
    bus.if_addr  = ia;
    bus.dm_req   = use_dm;
    bus.dm_we    = we;
    bus.dm_size  = sz;
    bus.dm_addr  = da;
    bus.dm_wdata = wd;
    if (first_dm) serve(1'b1, we, sz, da, wd, l, h, rd0);
    else          serve(1'b0, 1'b0, 2'd2, ia, 32'h0, l, h, rd0);
    last_dm_m = first_dm;
    if (use_if && use_dm) begin
      if (first_dm) serve(1'b0, 1'b0, 2'd2, ia, 32'h0, l, h, rd1);
      else          serve(1'b1, we, sz, da, wd, l, h, rd1);
      last_dm_m = !first_dm;
    end
  endtask

  task automatic check_reset_zero(input string tag);
    check({tag, "_ctrl"}, {bus.ram_mfa, bus.ram_rw, bus.busy, bus.if_done, bus.dm_done, bus.align_err}, 64'h0);
    check({tag, "_cmd"}, {bus.ram_addr, bus.ram_size}, 64'h0);
    check({tag, "_wdata"}, bus.ram_wdata, 64'h0);
    check({tag, "_rdata"}, {bus.if_rdata, bus.dm_rdata}, 64'h0);
`ifdef ARB_TIMEOUT_EN
    check({tag, "_timeout_err"}, bus.timeout_err, 1'b0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    automatic int start;
    automatic int pat;
    automatic logic [ADDR_W-1:0] ia, da;
    automatic logic [1:0] sz;
    reset        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_size  = 2'b00;
    bus.dm_addr  = '0;
    bus.dm_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_reset_zero("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_zero("after_reset");

    // Fetch from 0x010, MOC one cycle after MFA
    start = cyc;
    do_round(1'b1, 9'h010, 1'b0, 1'b0, 2'd0, '0, 32'h0, 1, 0, 32'h2009000A, 32'h0);
    check("fetch_turnaround", cyc - start, 4);
    check("fetch_rdata", bus.if_rdata, 32'h2009000A);

    // Contest: store byte 0x5A at 0x021 against a fetch
    do_round(1'b1, 9'h040, 1'b1, 1'b1, 2'd0, 9'h021, 32'h0000005A, 0, 0, 32'h11111111, 32'h22222222);

    // Misaligned halfword load is rejected
    do_round(1'b0, '0, 1'b1, 1'b0, 2'd1, 9'h023, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0);

    // RAM holds MOC three cycles after MFA falls
    do_round(1'b0, '0, 1'b1, 1'b0, 2'd2, 9'h044, 32'h0, 1, 3, 32'hCAFEF00D, 32'h0);

`ifdef ARB_TIMEOUT_EN
    // RAM never answers: watchdog completes the access
    mute         = 1'b1;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_size  = 2'd2;
    bus.dm_addr  = 9'h048;
    start        = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.dm_done) break;
    end
    check("timeout_done_cycle", cyc - start, 16);
    check("timeout_dm_done", bus.dm_done, 1'b1);
    check("timeout_rdata", bus.dm_rdata, exp_dm);
    check("timeout_err_set", bus.timeout_err, 1'b1);
    bus.dm_req = 1'b0;
    mute       = 1'b0;
    last_dm_m  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    repeat (3) @(negedge clk);
    check("timeout_err_sticky", bus.timeout_err, 1'b1);
`endif

    // Reset asserted in the middle of an access
    mute         = 1'b1;
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b0;
    bus.dm_size  = 2'd2;
    bus.dm_addr  = 9'h080;
    repeat (3) @(negedge clk);
    check("pre_reset_mfa", bus.ram_mfa, 1'b1);
    reset = 1'b0;
    #1;
    check_reset_zero("mid_reset");
    bus.dm_req = 1'b0;
    mute       = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    last_dm_m = 1'b0;
    exp_if    = 32'h0;
    exp_dm    = 32'h0;
    @(negedge clk);
    do_round(1'b1, 9'h100, 1'b1, 1'b1, 2'd0, 9'h021, 32'h0000005A, 0, 1, 32'h33333333, 32'h44444444);

    // Randomized traffic
    for (int r = 0; r < 60; r++) begin
      pat = $urandom_range(1, 3);
      ia  = ADDR_W'($urandom);
      if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
      da  = ADDR_W'($urandom);
      if ($urandom_range(0, 3) != 0) da[1:0] = 2'b00;
      sz  = 2'($urandom_range(0, 3));
      do_round(pat[0], ia, pat[1], 1'($urandom_range(0, 1)), sz, da, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram_access_arbiter.md
# ram_access_arbiter

Single-port RAM arbiter and access sequencer for the multicycle MIPS datapath. Shares one RAM between instruction fetch and data load/store requesters. Grants the requesters round-robin, performs a four-phase MFA/MOC handshake with the RAM, and returns read data with a one-cycle done pulse. Misaligned requests are rejected without touching the RAM.

## Interface
- `ADDR_W`, 9: byte address width.
- `TIMEOUT`, 15: maximum ACCESS cycles allowed without MOC. Used only with `ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`, `if_addr`  in  1, ADDR_W  fetch request (level) and byte address. A fetch is always a word read.
- `if_rdata`  out  32  fetched word.
- `if_done`  out  1  one-cycle pulse marking fetch completion.
- `dm_req`, `dm_we`  in  1, 1  data request (level) and write enable (1 = store).
- `dm_size`  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- `dm_addr`, `dm_wdata`  in  ADDR_W, 32  data address and store data.
- `dm_rdata`, `dm_done`  out  32, 1  load data and one-cycle completion pulse.
- `ram_mfa`  out  1  memory function active.
- `ram_rw`  out  1  1 = read, 0 = write.
- `ram_addr`, `ram_size`, `ram_wdata`  out  ADDR_W, 2, 32  registered RAM command fields.
- `ram_rdata`, `ram_moc`  in  32, 1  RAM read data and memory-operation-complete.
- `busy`  out  1  high in every state except IDLE.
- `align_err`  out  1  one-cycle pulse issued with the done of a rejected request.
- `timeout_err`  out  1  sticky timeout flag. Present only with `ARB_TIMEOUT_EN`.

## Operation
- FSM states: IDLE, ACCESS, RELEASE, REJECT. Reset puts the FSM in IDLE.
- **Reset values:** all outputs 0, including `if_rdata`/`dm_rdata` (32'h0), `timeout_err`, `ram_mfa`. `last_grant` resets to IF.
- **IDLE, selection:**
  - Only one request pending: select it.
  - Both pending: select the requester opposite `last_grant`. After reset, the first contest therefore goes to DM.
  - Selection updates `last_grant`, whether the request is accepted or rejected.
- **IDLE, alignment check on the selected request:**
  - Misaligned means a fetch with `addr[1:0]`≠0, a halfword with `addr[0]`=1, or a word with `addr[1:0]`≠0.
  - Misaligned → REJECT.
  - Aligned → latch the `ram_*` fields and go to ACCESS. Fetch latches `rw`=1, `size`=10.
- **ACCESS:** `ram_mfa`=1 and the `ram_*` fields stay frozen. When `ram_moc`=1 is sampled:
  - On a read, capture `ram_rdata` into the granted requester's `rdata` register.
  - Pulse that requester's done in the next cycle and go to RELEASE.
- **RELEASE:** `ram_mfa`=0. Stay until `ram_moc`=0 is sampled, then go to IDLE. This completes the four-phase handshake.
- **REJECT:** lasts one cycle. Done and `align_err` are both high. `rdata` keeps its previous value. Next state is IDLE.
- **Request fields:** sampled only at the grant. Dropping `req` during ACCESS does not abort the access.
- **Store write data:** `dm_rdata` is unchanged on stores.

## Timing
- Request high in IDLE during cycle N → `ram_mfa` high from cycle N+1.
- MOC first sampled high at the edge ending cycle M → done high during cycle M+1 only.
- With a combinational RAM (MOC in cycle N+1): done in N+2, RELEASE in N+2, IDLE in N+3. Minimum turnaround is therefore 3 cycles per access.
- Requesters must drop `req` by the edge ending their done cycle. A `req` still high in the following IDLE cycle is treated as a new request.
- Rejected request: done and `align_err` in cycle N+1, IDLE in N+2.
- Asserting `reset` at any time, including mid-ACCESS, drops `ram_mfa` and all done pulses immediately (asynchronous). An in-flight access is lost. A MOC still high after reset is ignored in IDLE.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A 4-bit-minimum counter, clearing on entry to ACCESS, counts ACCESS cycles.
  - If it reaches `TIMEOUT` without MOC, the arbiter drops `ram_mfa`, pulses the granted requester's done with `rdata` unchanged, sets `timeout_err` (sticky until reset), and goes to RELEASE.
- `ARB_TIMEOUT_EN` undefined: no counter and no `timeout_err` port. ACCESS waits for MOC indefinitely.

## Test plan
- Fetch `if_addr`=0x010, RAM returns 32'h2009000A with MOC one cycle after MFA → `if_done` 1 cycle, `if_rdata`=32'h2009000A, `ram_rw`=1, `ram_size`=10, back in IDLE 4 cycles after request.
- `if_req` and `dm_req` (store byte 0x5A at 0x021) asserted together after reset → DM granted first (`ram_rw`=0, `ram_size`=00, `ram_wdata`=0x5A). The fetch is granted in the IDLE cycle right after DM's RELEASE.
- Data halfword load at 0x023 → no MFA; `dm_done` and `align_err` high in cycle N+1; `dm_rdata` unchanged.
- RAM holds MOC high 3 cycles after MFA drops → arbiter stays in RELEASE with `busy`=1 and issues no new MFA until MOC falls.
- Reset pulsed low mid-ACCESS → `ram_mfa`=0, `busy`=0, outputs zero that cycle; after release a fresh `dm_req` is granted first.
- With `ARB_TIMEOUT_EN`, `TIMEOUT`=15, MOC never returned → `dm_done` pulse after 15 ACCESS cycles, `timeout_err`=1 held until reset.
